mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-requester arbiter that shares the single data port of the synchronous dual-port RAM between the instruction-fetch unit (IF) and the load/store unit (LS). It sits between the pipeline front/back ends and the memory controller's RAM port. It issues at most one access per cycle with fixed LS priority plus an anti-starvation counter for IF. It tracks the one-cycle read latency with a response tag so each read return is routed to its owner.

## Interface
Parameters:
- ADDR_W, 13, dword address width driven to RAM (byte address bits [ADDR_W+2:3])
- STARVE_LIMIT, 4, consecutive IF losses after which IF wins the next grant

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset; asynchronous, active-low
- if_req_i  in  1  IF request valid
- if_addr_i  in  DATA_WIDTH  IF byte address
- if_ready_o  out  1  IF request accepted this cycle (combinational)
- if_rvalid_o  out  1  IF response valid
- if_rdata_o  out  INST_WIDTH  fetched instruction
- if_err_o  out  1  IF response is misaligned-PC error (qualifies if_rvalid_o)
- flush_i  in  1  pipeline redirect: drop IF grant and IF response this cycle
- ls_req_i  in  1  LS request valid
- ls_we_i  in  1  1 = store, 0 = load
- ls_addr_i  in  DATA_WIDTH  LS byte address
- ls_be_i  in  8  byte enables (already shifted by LS)
- ls_wdata_i  in  DATA_WIDTH  store data (already lane-aligned)
- ls_ready_o  out  1  LS request accepted this cycle (combinational)
- ls_rvalid_o  out  1  LS response valid (load data or store ack)
- ls_rdata_o  out  DATA_WIDTH  raw dword read (LS does extension)
- mem_addr_o  out  ADDR_W  RAM dword address
- mem_be_o  out  8  RAM byte enables
- mem_wdata_o  out  DATA_WIDTH  RAM write data
- mem_re_o / mem_we_o  out  1 each  RAM read / write enable
- mem_rdata_i  in  DATA_WIDTH  RAM read data, valid one cycle after mem_re_o

## Operation
- Handshake: a request is accepted at the rising edge where req && ready. The requester holds its request stable until accepted. Responses cannot be back-pressured.
- Grant, per cycle: LS wins if ls_req_i, unless starve_cnt == STARVE_LIMIT and if_req_i, in which case IF wins. IF is never granted while flush_i = 1.
- starve_cnt: increments (saturating at STARVE_LIMIT) each cycle if_req_i && !flush_i && LS granted. Clears to 0 on IF grant or when if_req_i = 0.
- LS grant: mem_addr_o = ls_addr_i[ADDR_W+2:3], mem_be_o = ls_be_i, mem_we_o = ls_we_i, mem_re_o = !ls_we_i.
- IF grant with if_addr_i[1:0] == 0: mem_re_o = 1, mem_be_o = 8'hff, mem_we_o = 0, sel_hi_q <= if_addr_i[2].
- IF grant with if_addr_i[1:0] != 0: accepted, no RAM access (mem_re_o = 0), response is the error response.
- Response tag FSM tag_q: NONE, IF_RD, IF_ERR, LS_RD, LS_WR. It loads on every edge from the current grant (NONE if no grant), so there is no stall state and throughput is 1 access/cycle.
- Tag state outputs:
  - IF_RD: if_rvalid_o = !flush_i; if_rdata_o = sel_hi_q ? mem_rdata_i[63:32] : mem_rdata_i[31:0].
  - IF_ERR: if_rvalid_o = !flush_i, if_err_o = 1, if_rdata_o = 0.
  - LS_RD: ls_rvalid_o = 1, ls_rdata_o = mem_rdata_i.
  - LS_WR: ls_rvalid_o = 1, ls_rdata_o = 0.
- No grant: all mem_* outputs are 0.

## Timing
- Reset (async assert): tag_q = NONE, sel_hi_q = 0, starve_cnt = 0. All response outputs are 0 immediately. Ready and mem enables are 0 while rst_n = 0.
- Accept at edge T → RAM samples at edge T → response valid in cycle T+1 (combinational from mem_rdata_i).
- Back-to-back grants to different requesters are legal. The response to the cycle-T grant and the cycle-T+1 issue overlap.
- flush_i during an IF_RD/IF_ERR response cycle suppresses if_rvalid_o and the response is lost. An LS response is never affected.
- Reset mid-operation: a pending response is discarded and no rvalid appears after release.

## Structure
- utils_pkg gains:
  - typedef enum arb_tag_t {TAG_NONE, TAG_IF_RD, TAG_IF_ERR, TAG_LS_RD, TAG_LS_WR}
  - localparam DWORD_OFS = 3
- Reuses DATA_WIDTH and INST_WIDTH from utils_pkg.
- Single module. Grant logic is one always_comb. Tag, sel_hi and counter are one always_ff on posedge clk / negedge rst_n. No sub-module.

## Test plan
- IF only, addr 0x104, RAM dword 0x20 = 0xAAAA_BBBB_1111_2222 → if_ready_o = 1, mem_addr_o = 0x20; next cycle if_rvalid_o = 1, if_rdata_o = 0xAAAABBBB.
- LS store be = 8'h0f at 0x40, then load 0x40 next cycle → mem_we_o then mem_re_o; ls_rvalid_o on both following cycles; load returns the written low word.
- IF and LS requesting continuously, STARVE_LIMIT = 4 → grants LS,LS,LS,LS,IF repeating; starve_cnt returns to 0 after the IF grant.
- IF addr 0x102 → mem_re_o = 0; next cycle if_rvalid_o = 1, if_err_o = 1, if_rdata_o = 0.
- IF accepted at T, flush_i = 1 at T+1 → if_rvalid_o = 0 at T+1, if_ready_o = 0 at T+1.
- Load accepted, rst_n pulled low in the response cycle → ls_rvalid_o drops to 0 immediately, and no response appears after reset release.

Source files
------------

// File: rtl/utils_pkg.sv
// utils_pkg: shared widths, response tag encoding and address constants
package utils_pkg;
  localparam int DATA_WIDTH = 64;
  localparam int INST_WIDTH = 32;
  localparam int DWORD_OFS  = 3;
  typedef enum logic [2:0] {
    TAG_NONE,
    TAG_IF_RD,
    TAG_IF_ERR,
    TAG_LS_RD,
    TAG_LS_WR
  } arb_tag_t;
endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one RAM port between instruction fetch and load/store, routing read returns by tag
module mem_arbiter
  import utils_pkg::*;
#(
  parameter int ADDR_W       = 13,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  if_req_i,
  input  logic [DATA_WIDTH-1:0] if_addr_i,
  output logic                  if_ready_o,
  output logic                  if_rvalid_o,
  output logic [INST_WIDTH-1:0] if_rdata_o,
  output logic                  if_err_o,
  input  logic                  flush_i,
  input  logic                  ls_req_i,
  input  logic                  ls_we_i,
  input  logic [DATA_WIDTH-1:0] ls_addr_i,
  input  logic [7:0]            ls_be_i,
  input  logic [DATA_WIDTH-1:0] ls_wdata_i,
  output logic                  ls_ready_o,
  output logic                  ls_rvalid_o,
  output logic [DATA_WIDTH-1:0] ls_rdata_o,
  output logic [ADDR_W-1:0]     mem_addr_o,
  output logic [7:0]            mem_be_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  output logic                  mem_re_o,
  output logic                  mem_we_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);
  arb_tag_t         tag_q, tag_d;
  logic             sel_hi_q, sel_hi_d;
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic             if_ok, if_win, ls_win, if_aligned, if_rd;
  logic             unused_addr;
  assign unused_addr = ^{if_addr_i[DATA_WIDTH-1:ADDR_W+DWORD_OFS],
                         ls_addr_i[DATA_WIDTH-1:ADDR_W+DWORD_OFS],
                         ls_addr_i[DWORD_OFS-1:0]};
  // Grant selection, RAM drive and next-state for tag, word select and starvation counter
  always_comb begin
    if_aligned   = if_addr_i[1:0] == 2'b00;
    if_ok        = rst_n && if_req_i && !flush_i;
    if_win       = if_ok && (!ls_req_i || starve_cnt_q == LIMIT);
    ls_win       = rst_n && ls_req_i && !if_win;
    if_rd        = if_win && if_aligned;
    if_ready_o   = if_win;
    ls_ready_o   = ls_win;
    mem_re_o     = if_rd || (ls_win && !ls_we_i);
    mem_we_o     = ls_win && ls_we_i;
    mem_addr_o   = ls_win ? ls_addr_i[ADDR_W+DWORD_OFS-1:DWORD_OFS]
                 : if_rd  ? if_addr_i[ADDR_W+DWORD_OFS-1:DWORD_OFS] : '0;
    mem_be_o     = ls_win ? ls_be_i : if_rd ? 8'hff : 8'h00;
    mem_wdata_o  = ls_win ? ls_wdata_i : '0;
    tag_d        = if_win ? (if_aligned ? TAG_IF_RD : TAG_IF_ERR)
                 : ls_win ? (ls_we_i ? TAG_LS_WR : TAG_LS_RD) : TAG_NONE;
    sel_hi_d     = if_rd ? if_addr_i[2] : sel_hi_q;
    starve_cnt_d = (if_win || !if_req_i) ? '0
                 : (if_ok && ls_win && starve_cnt_q != LIMIT) ? starve_cnt_q + 1'b1
                 : starve_cnt_q;
  end
  // Response tag, IF word select and starvation counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_q        <= TAG_NONE;
      sel_hi_q     <= 1'b0;
      starve_cnt_q <= '0;
    end else begin
      tag_q        <= tag_d;
      sel_hi_q     <= sel_hi_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end
  // Route the RAM return of last cycle's grant to its owner; flush drops IF responses only
  always_comb begin
    if_rvalid_o = (tag_q == TAG_IF_RD || tag_q == TAG_IF_ERR) && !flush_i;
    if_err_o    = tag_q == TAG_IF_ERR;
    if_rdata_o  = tag_q != TAG_IF_RD ? '0
                : sel_hi_q ? mem_rdata_i[DATA_WIDTH-1 -: INST_WIDTH] : mem_rdata_i[INST_WIDTH-1:0];
    ls_rvalid_o = tag_q == TAG_LS_RD || tag_q == TAG_LS_WR;
    ls_rdata_o  = tag_q == TAG_LS_RD ? mem_rdata_i : '0;
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: random and directed stimulus checked against a cycle-level behavioural model
module tb_mem_arbiter;
  import utils_pkg::*;
  localparam int LIM = 4;
  logic clk = 0, rst_n = 0;
  logic if_req_i = 0, flush_i = 0, ls_req_i = 0, ls_we_i = 0;
  logic [63:0] if_addr_i = 0, ls_addr_i = 0, ls_wdata_i = 0, mem_rdata_i;
  logic [7:0] ls_be_i = 0, mem_be_o;
  logic if_ready_o, if_rvalid_o, if_err_o, ls_ready_o, ls_rvalid_o, mem_re_o, mem_we_o;
  logic [31:0] if_rdata_o;
  logic [63:0] ls_rdata_o, mem_wdata_o;
  logic [12:0] mem_addr_o;
  int total = 0, bad = 0;
  logic [63:0] ram [0:8191];
  logic [63:0] mdl [0:8191];
  logic [63:0] rd_q;
  int losses, pk, pa, mg, cg;
  logic ph, acc_if, acc_ls, ev, lv, xre, xwe;
  logic [9:0] pat;

  mem_arbiter #(.ADDR_W(13), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_ready_o(if_ready_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o), .if_err_o(if_err_o),
    .flush_i(flush_i),
    .ls_req_i(ls_req_i), .ls_we_i(ls_we_i), .ls_addr_i(ls_addr_i), .ls_be_i(ls_be_i),
    .ls_wdata_i(ls_wdata_i), .ls_ready_o(ls_ready_o), .ls_rvalid_o(ls_rvalid_o),
    .ls_rdata_o(ls_rdata_o),
    .mem_addr_o(mem_addr_o), .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
    .mem_re_o(mem_re_o), .mem_we_o(mem_we_o), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  // 0 = no grant, 1 = IF, 2 = LS
  function automatic int grant();
    if (!rst_n) return 0;
    if (if_req_i && !flush_i && (!ls_req_i || losses == LIM)) return 1;
    if (ls_req_i) return 2;
    return 0;
  endfunction

  // RAM environment: byte-enabled writes, one-cycle read latency, junk when not reading
  always @(posedge clk) begin
    if (mem_we_o)
      for (int b = 0; b < 8; b++) if (mem_be_o[b]) ram[mem_addr_o][8*b +: 8] = mem_wdata_o[8*b +: 8];
    rd_q <= mem_re_o ? ram[mem_addr_o] : {$urandom, $urandom};
  end
  assign mem_rdata_i = rd_q;

  // Reference model: who wins, what response is owed next cycle, and the memory contents
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pk = 0; losses = 0; acc_if = 0; acc_ls = 0;
    end else begin
      mg = grant();
      acc_if = mg == 1;
      acc_ls = mg == 2;
      pk = mg == 1 ? (if_addr_i[1:0] == 0 ? 1 : 2) : mg == 2 ? (ls_we_i ? 4 : 3) : 0;
      pa = mg == 1 ? int'(if_addr_i[15:3]) : int'(ls_addr_i[15:3]);
      ph = if_addr_i[2];
      if (mg == 2 && ls_we_i)
        for (int b = 0; b < 8; b++) if (ls_be_i[b]) mdl[pa][8*b +: 8] = ls_wdata_i[8*b +: 8];
      if (mg == 1 || !if_req_i) losses = 0;
      else if (mg == 2 && !flush_i && losses < LIM) losses = losses + 1;
    end
  end

  // Compare every cycle, mid-period
  always @(negedge clk) begin
    cg = grant();
    xre = (cg == 1 && if_addr_i[1:0] == 0) || (cg == 2 && !ls_we_i);
    xwe = cg == 2 && ls_we_i;
    chk("if_ready", if_ready_o, cg == 1);
    chk("ls_ready", ls_ready_o, cg == 2);
    chk("mem_re", mem_re_o, xre);
    chk("mem_we", mem_we_o, xwe);
    if (cg == 0) begin
      chk("idle_addr", mem_addr_o, 0);
      chk("idle_be", mem_be_o, 0);
      chk("idle_wdata", mem_wdata_o, 0);
    end else if (xre || xwe) begin
      chk("mem_addr", mem_addr_o, cg == 1 ? if_addr_i[15:3] : ls_addr_i[15:3]);
      chk("mem_be", mem_be_o, cg == 1 ? 8'hff : ls_be_i);
      if (xwe) chk("mem_wdata", mem_wdata_o, ls_wdata_i);
    end
    ev = (pk == 1 || pk == 2) && !flush_i;
    lv = pk >= 3;
    chk("if_rvalid", if_rvalid_o, ev);
    if (ev) begin
      chk("if_err", if_err_o, pk == 2);
      chk("if_rdata", if_rdata_o, pk == 2 ? 32'h0 : ph ? mdl[pa][63:32] : mdl[pa][31:0]);
    end
    chk("ls_rvalid", ls_rvalid_o, lv);
    if (lv) chk("ls_rdata", ls_rdata_o, pk == 4 ? 64'h0 : mdl[pa]);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] ra();
    logic [63:0] a;
    a = {$urandom, $urandom};
    a[15:7] = '0;
    if ($urandom % 5 != 0) a[1:0] = 2'b00;
    return a;
  endfunction

  initial begin
    for (int i = 0; i < 8192; i++) begin
      ram[i] = i < 16 ? {$urandom, $urandom} : 64'h0;
      mdl[i] = ram[i];
    end
    ram[32] = 64'hAAAA_BBBB_1111_2222; mdl[32] = ram[32];
    ram[8]  = 64'h1122_3344_5566_7788; mdl[8]  = ram[8];
    if_req_i = 1; ls_req_i = 1;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_if_ready", if_ready_o, 0);
    chk("rst_ls_ready", ls_ready_o, 0);
    chk("rst_mem_re", mem_re_o, 0);
    chk("rst_rvalid", {if_rvalid_o, ls_rvalid_o}, 0);
    step(); rst_n = 1; if_req_i = 0; ls_req_i = 0;
    step(); if_req_i = 1; if_addr_i = 64'h104;
    #2; chk("if_acc_ready", if_ready_o, 1); chk("if_acc_addr", mem_addr_o, 13'h20); chk("if_acc_re", mem_re_o, 1);
    step(); if_req_i = 0;
    #2; chk("if_rsp_valid", if_rvalid_o, 1); chk("if_rsp_data", if_rdata_o, 32'hAAAABBBB); chk("if_rsp_err", if_err_o, 0);
    step(); if_req_i = 1; if_addr_i = 64'h102;
    #2; chk("mis_ready", if_ready_o, 1); chk("mis_re", mem_re_o, 0);
    step(); if_req_i = 0;
    #2; chk("mis_valid", if_rvalid_o, 1); chk("mis_err", if_err_o, 1); chk("mis_data", if_rdata_o, 0);
    step(); ls_req_i = 1; ls_we_i = 1; ls_addr_i = 64'h40; ls_be_i = 8'h0f; ls_wdata_i = 64'hDEADBEEF_CAFEF00D;
    #2; chk("st_we", mem_we_o, 1); chk("st_addr", mem_addr_o, 13'h8);
    step(); ls_we_i = 0;
    #2; chk("ld_re", mem_re_o, 1); chk("st_ack", ls_rvalid_o, 1); chk("st_ack_data", ls_rdata_o, 0);
    step(); ls_req_i = 0;
    #2; chk("ld_valid", ls_rvalid_o, 1); chk("ld_data", ls_rdata_o, 64'h11223344_CAFEF00D);
    step(); if_req_i = 1; if_addr_i = 64'h0; ls_req_i = 1; ls_we_i = 0; ls_addr_i = 64'h0;
    for (int i = 0; i < 10; i++) begin
      #2; pat[9-i] = ls_ready_o;
      step();
    end
    chk("starve_pattern", pat, 10'b1111011110);
    if_req_i = 0; ls_req_i = 0;
    step(); if_req_i = 1; if_addr_i = 64'h8;
    #2; chk("fl_acc", if_ready_o, 1);
    step(); flush_i = 1;
    #2; chk("fl_rvalid", if_rvalid_o, 0); chk("fl_ready", if_ready_o, 0);
    step(); flush_i = 0; if_req_i = 0; ls_req_i = 1; ls_we_i = 0; ls_addr_i = 64'h40;
    step(); ls_req_i = 0;
    #2; chk("rr_valid", ls_rvalid_o, 1);
    rst_n = 0;
    #1; chk("rr_drop", ls_rvalid_o, 0);
    step(); step(); rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      #2; chk("rr_after", {if_rvalid_o, ls_rvalid_o}, 0);
      step();
    end
    for (int c = 0; c < 3000; c++) begin
      step();
      if (!if_req_i || acc_if) begin
        if_req_i = ($urandom % 10) < 6;
        if_addr_i = ra();
      end
      if (!ls_req_i || acc_ls) begin
        ls_req_i = ($urandom % 10) < 6;
        ls_we_i = $urandom % 2;
        ls_addr_i = ra();
        ls_be_i = 8'($urandom);
        ls_wdata_i = {$urandom, $urandom};
      end
      flush_i = ($urandom % 6) == 0;
    end
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
